// File: rtl/calc_pkg.sv
// Shared constants and FSM encodings for the calculator digit-lane datapath.
package calc_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int MAX_DEC    = 9999;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_FINISH = 2'd2;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] nib_i,
    output logic [BCD_W-1:0] nib_o
);
    assign nib_o = (nib_i >= BCD_W'(5)) ? nib_i + BCD_W'(3) : nib_i;
endmodule

// File: rtl/quad_unshift.sv
// Binary-to-four-digit splitter using shift-add-3, one input bit per clock.
module quad_unshift
    import calc_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int DIG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  in_val,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [DIG_W-1:0] dig0,
    output logic [DIG_W-1:0] dig1,
    output logic [DIG_W-1:0] dig2,
    output logic [DIG_W-1:0] dig3
);
    // state     | meaning
    // ST_IDLE   | waiting for start, outputs hold last result
    // ST_SHIFT  | IN_W shift-add-3 steps, one input bit each
    // ST_FINISH | publish digits (or saturated 9999) and pulse done

    localparam int BCD_TOT = NUM_DIGITS * BCD_W;
    localparam int CNT_W   = 5;
    localparam logic [IN_W-1:0]  MAX_IN   = IN_W'(MAX_DEC);
    localparam logic [DIG_W-1:0] DIG_NINE = DIG_W'(9);

    state_t                               state_q, state_d;
    logic [IN_W-1:0]                      sreg_q, sreg_d;
    logic [BCD_TOT-1:0]                   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 ovf_pend_q, ovf_pend_d;
    logic                                 ovf_q, ovf_d;
    logic                                 done_q, done_d;
    logic [NUM_DIGITS-1:0][DIG_W-1:0]     dig_q, dig_d;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (bcd_q[g*BCD_W +: BCD_W]),
            .nib_o (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        dig_d      = dig_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    sreg_d     = in_val;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(IN_W);
                    ovf_pend_d = (in_val > MAX_IN);
                end
            end
            ST_SHIFT: begin
                bcd_d  = {bcd_adj[BCD_TOT-2:0], sreg_q[IN_W-1]};
                sreg_d = {sreg_q[IN_W-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                // a carry out of the thousands digit only happens when saturation is already pending
                ovf_pend_d = ovf_pend_q | bcd_adj[BCD_TOT-1];
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                ovf_d   = ovf_pend_q;
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    dig_d[k] = ovf_pend_q ? DIG_NINE : DIG_W'(bcd_q[k*BCD_W +: BCD_W]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            dig_q      <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            dig_q      <= dig_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign dig0 = dig_q[0];
    assign dig1 = dig_q[1];
    assign dig2 = dig_q[2];
    assign dig3 = dig_q[3];
endmodule

// File: tb/tb_quad_unshift.sv
// Directed-vector bench for quad_unshift with hand-computed digit results.
module tb_quad_unshift;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] in_val;
    logic        busy, done, ovf;
    logic [7:0]  dig0, dig1, dig2, dig3;

    int vec_cnt = 0;
    int err_cnt = 0;

    quad_unshift #(.IN_W(14), .DIG_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in_val (in_val),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .dig0   (dig0),
        .dig1   (dig1),
        .dig2   (dig2),
        .dig3   (dig3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dw(input int d3, input int d2, input int d1, input int d0);
        return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    // drives start for one edge, then waits (bounded) for done; lat=-1 on timeout
    task automatic run_conv(input logic [13:0] v, input bit scramble, output int lat, output bit busy1);
        in_val = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy1 = busy;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            if (scramble) in_val = 14'($urandom);
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_val = '0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        vec_cnt++; if ({dig3, dig2, dig1, dig0} !== 32'h0) begin err_cnt++; $display("FAIL reset_digits: got %h want 00000000", {dig3, dig2, dig1, dig0}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; bit b1;
        run_conv(14'd1234, 1'b0, lat, b1);
        vec_cnt++; if (b1 !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: got %b want 1", b1); end
        vec_cnt++; if (lat != 15) begin err_cnt++; $display("FAIL basic_latency: got %0d want 15", lat); end
        vec_cnt++; if ({dig3, dig2, dig1, dig0} !== dw(1, 2, 3, 4)) begin err_cnt++; $display("FAIL basic_digits: got %h want %h", {dig3, dig2, dig1, dig0}, dw(1, 2, 3, 4)); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL basic_idle_at_done: got %b want 0", busy); end
    endtask

    task automatic test_boundary();
        logic [13:0] vals [5] = '{14'd0, 14'd9999, 14'd10000, 14'd16383, 14'd7};
        logic [31:0] exp_d [5];
        logic        exp_o [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat; bit b1;
        exp_d[0] = dw(0, 0, 0, 0);
        exp_d[1] = dw(9, 9, 9, 9);
        exp_d[2] = dw(9, 9, 9, 9);
        exp_d[3] = dw(9, 9, 9, 9);
        exp_d[4] = dw(0, 0, 0, 7);
        for (int i = 0; i < 5; i++) begin
            run_conv(vals[i], 1'b0, lat, b1);
            vec_cnt++; if (lat != 15) begin err_cnt++; $display("FAIL boundary_latency[%0d]: got %0d want 15", vals[i], lat); end
            vec_cnt++; if ({dig3, dig2, dig1, dig0} !== exp_d[i]) begin err_cnt++; $display("FAIL boundary_digits[%0d]: got %h want %h", vals[i], {dig3, dig2, dig1, dig0}, exp_d[i]); end
            vec_cnt++; if (ovf !== exp_o[i]) begin err_cnt++; $display("FAIL boundary_ovf[%0d]: got %b want %b", vals[i], ovf, exp_o[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        int done_cnt = 0, done_at = -1, busy_cnt = 0, hold_bad = 0;
        in_val = 14'd4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 5) begin in_val = 14'd5555; start = 1'b1; end
            @(posedge clk); #1;
            if (n == 5) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; if (done_at < 0) done_at = n; end
            if (busy && ({dig3, dig2, dig1, dig0} !== dw(0, 0, 0, 7))) hold_bad++;
        end
        vec_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
        vec_cnt++; if (done_at != 15) begin err_cnt++; $display("FAIL busy_start_latency: got %0d want 15", done_at); end
        vec_cnt++; if (busy_cnt != 14) begin err_cnt++; $display("FAIL busy_start_busy_cycles: got %0d want 14", busy_cnt); end
        vec_cnt++; if (hold_bad != 0) begin err_cnt++; $display("FAIL busy_start_hold: got %0d changed samples want 0", hold_bad); end
        vec_cnt++; if ({dig3, dig2, dig1, dig0} !== dw(4, 3, 2, 1)) begin err_cnt++; $display("FAIL busy_start_digits: got %h want %h", {dig3, dig2, dig1, dig0}, dw(4, 3, 2, 1)); end
    endtask

    task automatic test_back_to_back();
        int lat, lat2 = -1, hold_bad = 0; bit b1;
        run_conv(14'd42, 1'b0, lat, b1);
        vec_cnt++; if ({dig3, dig2, dig1, dig0} !== dw(0, 0, 4, 2)) begin err_cnt++; $display("FAIL b2b_first_digits: got %h want %h", {dig3, dig2, dig1, dig0}, dw(0, 0, 4, 2)); end
        in_val = 14'd900; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat2 = n; break; end
            if ({dig3, dig2, dig1, dig0} !== dw(0, 0, 4, 2)) hold_bad++;
        end
        vec_cnt++; if (lat2 != 15) begin err_cnt++; $display("FAIL b2b_latency: got %0d want 15", lat2); end
        vec_cnt++; if (hold_bad != 0) begin err_cnt++; $display("FAIL b2b_hold: got %0d changed samples want 0", hold_bad); end
        vec_cnt++; if ({dig3, dig2, dig1, dig0} !== dw(0, 9, 0, 0)) begin err_cnt++; $display("FAIL b2b_second_digits: got %h want %h", {dig3, dig2, dig1, dig0}, dw(0, 9, 0, 0)); end
    endtask

    task automatic test_reset_mid();
        int lat, stray = 0; bit b1;
        in_val = 14'd8765; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_done: got %b want 0", done); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_ovf: got %b want 0", ovf); end
        vec_cnt++; if ({dig3, dig2, dig1, dig0} !== 32'h0) begin err_cnt++; $display("FAIL rst_mid_digits: got %h want 00000000", {dig3, dig2, dig1, dig0}); end
        @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        vec_cnt++; if (stray != 0) begin err_cnt++; $display("FAIL rst_mid_no_done: got %0d active samples want 0", stray); end
        run_conv(14'd305, 1'b0, lat, b1);
        vec_cnt++; if (lat != 15) begin err_cnt++; $display("FAIL rst_mid_after_latency: got %0d want 15", lat); end
        vec_cnt++; if ({dig3, dig2, dig1, dig0} !== dw(0, 3, 0, 5)) begin err_cnt++; $display("FAIL rst_mid_after_digits: got %h want %h", {dig3, dig2, dig1, dig0}, dw(0, 3, 0, 5)); end
    endtask

    task automatic test_input_stability();
        int lat; bit b1;
        run_conv(14'd2468, 1'b1, lat, b1);
        vec_cnt++; if (lat != 15) begin err_cnt++; $display("FAIL stable_latency: got %0d want 15", lat); end
        vec_cnt++; if ({dig3, dig2, dig1, dig0} !== dw(2, 4, 6, 8)) begin err_cnt++; $display("FAIL stable_digits: got %h want %h", {dig3, dig2, dig1, dig0}, dw(2, 4, 6, 8)); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL stable_ovf: got %b want 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_input_stability();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
